// File: rtl/cons_memory_unit.sv
// Cons-cell heap controller: allocates, reads, mutates and frees {type, car, cdr}
// words in an external fixed-latency RAM using a bump pointer plus a LIFO free list.
module cons_memory_unit #(
  parameter int ADDR_W   = 10,
  parameter int TYPE_W   = 4,
  parameter int READ_LAT = 2,
  parameter int HEAP_TOP = 2**ADDR_W-1,
  localparam int DATA_W  = TYPE_W + 2*ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        func,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [TYPE_W-1:0] type_info,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   heap_free
);

  // state     | meaning
  // INIT_RD   | present address 0 to fetch the saved bump pointer
  // INIT_WAIT | wait out the RAM read latency
  // INIT_CLR  | load bump pointer from word 0, then clear word 0
  // IDLE      | ready for a command
  // RD_WAIT   | CAR/CDR/CONTENTS read in flight
  // RMW_WAIT  | SET_CAR/SET_CDR read in flight
  // POP_WAIT  | CONS reading the free-list head for its link
  // WR        | read-modify-write or pop write issued; respond
  // RESP      | single-cycle commands and errors respond
  typedef enum logic [3:0] {
    INIT_RD, INIT_WAIT, INIT_CLR, IDLE, RD_WAIT, RMW_WAIT, POP_WAIT, WR, RESP
  } state_t;

  localparam logic [2:0] F_CAR      = 3'd0;
  localparam logic [2:0] F_CDR      = 3'd1;
  localparam logic [2:0] F_CONS     = 3'd2;
  localparam logic [2:0] F_CONTENTS = 3'd3;
  localparam logic [2:0] F_SET_CAR  = 3'd4;
  localparam logic [2:0] F_SET_CDR  = 3'd5;
  localparam logic [2:0] F_FREE     = 3'd6;

  localparam int           CNT_W     = 3;
  localparam logic [ADDR_W:0] HEAP_LAST = (ADDR_W+1)'(HEAP_TOP);
  localparam logic [ADDR_W:0] HEAP_END  = (ADDR_W+1)'(HEAP_TOP + 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W:0]     bump_q, bump_d;
  logic [ADDR_W-1:0]   free_head_q, free_head_d;
  logic [ADDR_W:0]     free_cnt_q, free_cnt_d;
  logic [ADDR_W-1:0]   link_q, link_d;
  logic [2:0]          func_q, func_d;
  logic [ADDR_W-1:0]   addr0_q, addr0_d;
  logic [ADDR_W-1:0]   addr1_q, addr1_d;
  logic [TYPE_W-1:0]   type_q, type_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wren_q, mem_wren_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;

  logic                heap_full;
  logic [ADDR_W:0]     bump_room;
  logic [TYPE_W-1:0]   rd_type;
  logic [ADDR_W-1:0]   rd_car, rd_cdr;

  assign rd_type   = mem_rdata[DATA_W-1:2*ADDR_W];
  assign rd_car    = mem_rdata[2*ADDR_W-1:ADDR_W];
  assign rd_cdr    = mem_rdata[ADDR_W-1:0];
  assign heap_full = (bump_q > HEAP_LAST);
  assign bump_room = heap_full ? '0 : (HEAP_END - bump_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bump_d      = bump_q;
    free_head_d = free_head_q;
    free_cnt_d  = free_cnt_q;
    link_d      = link_q;
    func_d      = func_q;
    addr0_d     = addr0_q;
    addr1_d     = addr1_q;
    type_d      = type_q;
    mem_addr_d  = mem_addr_q;
    mem_wren_d  = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    err_d       = 1'b0;
    addr_out_d  = addr_out_q;
    data_out_d  = data_out_q;

    case (state_q)
      INIT_RD: begin
        mem_addr_d = '0;
        cnt_d      = CNT_W'(READ_LAT - 1);
        state_d    = INIT_WAIT;
      end
      INIT_WAIT: begin
        if (cnt_q == '0) state_d = INIT_CLR;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      INIT_CLR: begin
        bump_d      = {1'b0, rd_cdr};
        mem_addr_d  = '0;
        mem_wren_d  = 1'b1;
        mem_wdata_d = '0;
        state_d     = IDLE;
      end
      IDLE: begin
        if (cmd_valid) begin
          func_d  = func;
          addr0_d = addr0;
          addr1_d = addr1;
          type_d  = type_info;
          cnt_d   = CNT_W'(READ_LAT);
          state_d = RESP;
          case (func)
            F_CAR, F_CDR, F_CONTENTS: begin
              if (addr0 != '0) begin
                mem_addr_d = addr0;
                state_d    = RD_WAIT;
              end
            end
            F_CONS: begin
              if (free_head_q != '0) begin
                mem_addr_d = free_head_q;
                state_d    = POP_WAIT;
              end else if (!heap_full) begin
                mem_addr_d  = bump_q[ADDR_W-1:0];
                mem_wren_d  = 1'b1;
                mem_wdata_d = {type_info, addr0, addr1};
              end
            end
            F_SET_CAR, F_SET_CDR: begin
              if (addr0 != '0) begin
                mem_addr_d = addr0;
                state_d    = RMW_WAIT;
              end
            end
            F_FREE: begin
              if (addr0 != '0) begin
                mem_addr_d  = addr0;
                mem_wren_d  = 1'b1;
                mem_wdata_d = {{(TYPE_W+ADDR_W){1'b0}}, free_head_q};
              end
            end
            default: ;
          endcase
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
          case (func_q)
            F_CAR:   addr_out_d = rd_car;
            F_CDR:   addr_out_d = rd_cdr;
            default: data_out_d = mem_rdata;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      POP_WAIT: begin
        if (cnt_q == '0) begin
          link_d      = rd_cdr;
          mem_wren_d  = 1'b1;
          mem_wdata_d = {type_q, addr0_q, addr1_q};
          state_d     = WR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RMW_WAIT: begin
        if (cnt_q == '0) begin
          mem_wren_d  = 1'b1;
          mem_wdata_d = (func_q == F_SET_CAR) ? {rd_type, addr1_q, rd_cdr}
                                              : {rd_type, rd_car, addr1_q};
          state_d     = WR;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
        if (func_q == F_CONS) begin
          // free_head_q still names the popped cell until this edge
          addr_out_d  = free_head_q;
          free_head_d = link_q;
          free_cnt_d  = free_cnt_q - (ADDR_W+1)'(1);
        end else begin
          addr_out_d = addr0_q;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
        case (func_q)
          F_CAR, F_CDR: addr_out_d = '0;
          F_CONTENTS:   data_out_d = '0;
          F_CONS: begin
            if (heap_full) begin
              err_d      = 1'b1;
              addr_out_d = '0;
            end else begin
              addr_out_d = bump_q[ADDR_W-1:0];
              bump_d     = bump_q + (ADDR_W+1)'(1);
            end
          end
          F_SET_CAR, F_SET_CDR: begin
            err_d      = 1'b1;
            addr_out_d = addr0_q;
          end
          F_FREE: begin
            if (addr0_q == '0) begin
              err_d = 1'b1;
            end else begin
              free_head_d = addr0_q;
              free_cnt_d  = free_cnt_q + (ADDR_W+1)'(1);
            end
          end
          default: ;
        endcase
      end
      default: state_d = INIT_RD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= INIT_RD;
      cnt_q       <= '0;
      bump_q      <= '0;
      free_head_q <= '0;
      free_cnt_q  <= '0;
      link_q      <= '0;
      func_q      <= '0;
      addr0_q     <= '0;
      addr1_q     <= '0;
      type_q      <= '0;
      mem_addr_q  <= '0;
      mem_wren_q  <= 1'b0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      addr_out_q  <= '0;
      data_out_q  <= '0;
    end else if (power) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bump_q      <= bump_d;
      free_head_q <= free_head_d;
      free_cnt_q  <= free_cnt_d;
      link_q      <= link_d;
      func_q      <= func_d;
      addr0_q     <= addr0_d;
      addr1_q     <= addr1_d;
      type_q      <= type_d;
      mem_addr_q  <= mem_addr_d;
      mem_wren_q  <= mem_wren_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign err       = err_q;
  assign addr_out  = addr_out_q;
  assign data_out  = data_out_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wren  = mem_wren_q;
  assign mem_wdata = mem_wdata_q;
  assign heap_free = bump_room + free_cnt_q;

endmodule

// File: tb/tb_cons_memory_unit.sv
// Bench for cons_memory_unit: three instances at READ_LAT 1..3, each with its own
// latency-accurate RAM model; instance 1 (READ_LAT=2) carries the main vector table.
module tb_cons_memory_unit;
  localparam int AW = 6;
  localparam int TW = 4;
  localparam int HT = 15;
  localparam int DW = TW + 2*AW;

  localparam int CAR = 0, CDR = 1, CONS = 2, CONTENTS = 3;
  localparam int SET_CAR = 4, SET_CDR = 5, FREE = 6, NOP = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, power, pre_en;
  logic [DW-1:0] pre_val;
  logic          cv [3];
  logic [2:0]    fn [3];
  logic [AW-1:0] a0 [3];
  logic [AW-1:0] a1 [3];
  logic [TW-1:0] ti [3];
  logic          cr [3];
  logic          rv [3];
  logic          er [3];
  logic [AW-1:0] ao [3];
  logic [DW-1:0] dout [3];
  logic [AW-1:0] ma [3];
  logic          mw [3];
  logic [DW-1:0] mwd [3];
  logic [DW-1:0] mrd [3];
  logic [AW:0]   hf [3];

  int cyc;
  int wrc [3];
  int n_pass, n_tot;

  genvar g;
  for (g = 0; g < 3; g++) begin : u
    logic [DW-1:0] ram [0:2**AW-1];
    logic [DW-1:0] pipe [0:g];

    cons_memory_unit #(.ADDR_W(AW), .TYPE_W(TW), .READ_LAT(g+1), .HEAP_TOP(HT)) dut (
      .clk(clk), .rst(rst_n), .power(power),
      .cmd_valid(cv[g]), .cmd_ready(cr[g]), .func(fn[g]),
      .addr0(a0[g]), .addr1(a1[g]), .type_info(ti[g]),
      .rsp_valid(rv[g]), .addr_out(ao[g]), .data_out(dout[g]), .err(er[g]),
      .mem_addr(ma[g]), .mem_wren(mw[g]), .mem_wdata(mwd[g]), .mem_rdata(mrd[g]),
      .heap_free(hf[g]));

    always @(posedge clk) begin
      if (mw[g]) ram[ma[g]] <= mwd[g];
      if (pre_en) ram[0] <= pre_val;
      pipe[0] <= ram[ma[g]];
      for (int i = 1; i <= g; i++) pipe[i] <= pipe[i-1];
    end
    assign mrd[g] = pipe[g];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int j = 0; j < 3; j++) if (mw[j]) wrc[j] <= wrc[j] + 1;
  end

  typedef struct {
    int f, x0, x1, t;
    int ca, ea;
    int cd;
    logic [DW-1:0] ed;
    int ee, el, ew, ehf;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] wd(input int t, input int a, input int d);
    return {TW'(t), AW'(a), AW'(d)};
  endfunction

  function automatic vec_t mk(input int f, x0, x1, t, ca, ea, cd, input logic [DW-1:0] ed,
                              input int ee, el, ew, ehf);
    vec_t v;
    v.f = f; v.x0 = x0; v.x1 = x1; v.t = t; v.ca = ca; v.ea = ea; v.cd = cd; v.ed = ed;
    v.ee = ee; v.el = el; v.ew = ew; v.ehf = ehf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Issues one command on instance k; lat = edges from accept to rsp_valid, -1 on timeout.
  task automatic do_cmd(input int k, f, x0, x1, t, gap, output int lat);
    int  t_acc;
    bit  got;
    lat = -1;
    got = 0;
    @(negedge clk);
    fn[k] = 3'(f); a0[k] = AW'(x0); a1[k] = AW'(x1); ti[k] = TW'(t); cv[k] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cr[k]) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      cv[k] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    cv[k] = 1'b0;
    t_acc = cyc;
    if (gap > 0) begin
      power = 1'b0;
      repeat (gap) @(negedge clk);
      power = 1'b1;
    end
    for (int i = 0; i < 100; i++) begin
      if (rv[k]) begin lat = cyc - t_acc; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(input int k, output int rsp_seen);
    bit got;
    got = 0;
    rsp_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rv[k]) rsp_seen++;
      if (cr[k]) begin got = 1; break; end
    end
    chk("init_ready", got, 1);
  endtask

  initial begin
    int lat, w0, rs;
    vec_t v;
    n_pass = 0; n_tot = 0;
    for (int k = 0; k < 3; k++) begin
      cv[k] = 0; fn[k] = 3'(NOP); a0[k] = '0; a1[k] = '0; ti[k] = '0;
    end
    power = 1'b1; rst_n = 1'b0; pre_en = 1'b1; pre_val = DW'(5);

    tbl.push_back(mk(CONS,     3, 7, 2, 1, 5, 0, '0,          0, 1, 1, 10));
    tbl.push_back(mk(CAR,      5, 0, 0, 1, 3, 0, '0,          0, 3, 0, 10));
    tbl.push_back(mk(CDR,      5, 0, 0, 1, 7, 0, '0,          0, 3, 0, 10));
    tbl.push_back(mk(CONTENTS, 5, 0, 0, 0, 0, 1, wd(2, 3, 7), 0, 3, 0, 10));
    tbl.push_back(mk(CAR,      0, 0, 0, 1, 0, 0, '0,          0, 1, 0, 10));
    tbl.push_back(mk(CONTENTS, 0, 0, 0, 0, 0, 1, '0,          0, 1, 0, 10));
    tbl.push_back(mk(SET_CDR,  5, 9, 0, 1, 5, 0, '0,          0, 4, 1, 10));
    tbl.push_back(mk(CONTENTS, 5, 0, 0, 0, 0, 1, wd(2, 3, 9), 0, 3, 0, 10));
    tbl.push_back(mk(SET_CAR,  0, 1, 0, 0, 0, 0, '0,          1, 1, 0, 10));
    tbl.push_back(mk(NOP,      0, 0, 0, 0, 0, 0, '0,          0, 1, 0, 10));
    tbl.push_back(mk(CONS,     1, 2, 1, 1, 6, 0, '0,          0, 1, 1, 9));
    tbl.push_back(mk(FREE,     5, 0, 0, 0, 0, 0, '0,          0, 1, 1, 10));
    tbl.push_back(mk(FREE,     6, 0, 0, 0, 0, 0, '0,          0, 1, 1, 11));
    tbl.push_back(mk(CONS,     4, 4, 3, 1, 6, 0, '0,          0, 4, 1, 10));
    tbl.push_back(mk(CONS,     8, 8, 3, 1, 5, 0, '0,          0, 4, 1, 9));
    tbl.push_back(mk(CONS,     1, 1, 1, 1, 7, 0, '0,          0, 1, 1, 8));
    tbl.push_back(mk(CONTENTS, 6, 0, 0, 0, 0, 1, wd(3, 4, 4), 0, 3, 0, 8));
    tbl.push_back(mk(FREE,     0, 0, 0, 0, 0, 0, '0,          1, 1, 0, 8));
    tbl.push_back(mk(SET_CDR,  0, 3, 0, 0, 0, 0, '0,          1, 1, 0, 8));
    tbl.push_back(mk(CDR,      7, 0, 0, 1, 1, 0, '0,          0, 3, 0, 8));

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cr[1], 0);
    chk("rst_rsp_valid", rv[1], 0);
    chk("rst_err", er[1], 0);
    chk("rst_addr_out", ao[1], 0);
    chk("rst_data_out", dout[1], 0);
    chk("rst_mem_wren", mw[1], 0);
    chk("rst_mem_addr", ma[1], 0);
    chk("rst_heap_free", hf[1], HT + 1);

    pre_en = 1'b0;
    rst_n = 1'b1;
    wait_ready(1, rs);
    repeat (2) @(negedge clk);
    chk("init_word0_cleared", u[1].ram[0], 0);
    chk("init_heap_free", hf[1], HT + 1 - 5);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      w0 = wrc[1];
      do_cmd(1, v.f, v.x0, v.x1, v.t, 0, lat);
      chk($sformatf("v%0d_latency", i), lat, v.el);
      chk($sformatf("v%0d_err", i), er[1], v.ee);
      chk($sformatf("v%0d_writes", i), wrc[1] - w0, v.ew);
      chk($sformatf("v%0d_heap_free", i), hf[1], v.ehf);
      if (v.ca != 0) chk($sformatf("v%0d_addr_out", i), ao[1], v.ea);
      if (v.cd != 0) chk($sformatf("v%0d_data_out", i), dout[1], v.ed);
    end

    // fill the bump region up to HEAP_TOP, then one more CONS must fail
    for (int c = 8; c <= HT; c++) begin
      do_cmd(1, CONS, c, c, 1, 0, lat);
      chk($sformatf("fill_%0d_addr", c), ao[1], c);
    end
    chk("fill_heap_free", hf[1], 0);
    w0 = wrc[1];
    do_cmd(1, CONS, 2, 2, 2, 0, lat);
    chk("full_err", er[1], 1);
    chk("full_addr_out", ao[1], 0);
    chk("full_writes", wrc[1] - w0, 0);
    do_cmd(1, CDR, 5, 0, 0, 0, lat);
    chk("cdr5_addr", ao[1], 8);
    do_cmd(1, CAR, 0, 0, 0, 0, lat);
    chk("car_nil_addr", ao[1], 0);
    chk("car_nil_err", er[1], 0);

    // clock enable dropped for 10 cycles while the read is in flight
    do_cmd(1, CAR, 5, 0, 0, 10, lat);
    chk("pwr_latency", lat, 13);
    chk("pwr_addr", ao[1], 8);

    // reset during POP_WAIT
    do_cmd(1, FREE, 9, 0, 0, 0, lat);
    chk("free9_heap_free", hf[1], 1);
    @(negedge clk);
    fn[1] = 3'(CONS); a0[1] = AW'(1); a1[1] = AW'(2); ti[1] = TW'(1); cv[1] = 1'b1;
    for (int i = 0; i < 20 && !cr[1]; i++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    cv[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    pre_en = 1'b1;
    pre_val = DW'(12);
    @(negedge clk);
    pre_en = 1'b0;
    chk("rst2_rsp_valid", rv[1], 0);
    chk("rst2_cmd_ready", cr[1], 0);
    chk("rst2_heap_free", hf[1], HT + 1);
    rst_n = 1'b1;
    wait_ready(1, rs);
    chk("rst2_no_response", rs, 0);
    repeat (2) @(negedge clk);
    chk("rst2_word0_cleared", u[1].ram[0], 0);
    chk("rst2_init_heap_free", hf[1], HT + 1 - 12);
    do_cmd(1, CONS, 3, 3, 3, 0, lat);
    chk("rst2_cons_addr", ao[1], 12);

    // read latency at READ_LAT=1 and READ_LAT=3
    for (int k = 0; k < 3; k += 2) begin
      do_cmd(k, CONS, 3, 7, 2, 0, lat);
      chk($sformatf("rl%0d_cons_addr", k + 1), ao[k], 12);
      do_cmd(k, CAR, 12, 0, 0, 0, lat);
      chk($sformatf("rl%0d_car_latency", k + 1), lat, k + 2);
      chk($sformatf("rl%0d_car_addr", k + 1), ao[k], 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
